jtframe_sh: RTL and testbench

JTFRAME_SH -- requirements
Module: jtframe_sh

---
 rtl/jtframe_sh.sv | 66 ++++++
 tb/tb_jtframe_sh.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/jtframe_sh.sv
`default_nettype none
// ============================================================================
// Module  : jtframe_sh
// Brief   : clk_en-gated shift-register delay line with full tap view and a
//           fill tracker that flags when every stage holds fresh data.
// Revision: 1.0
// ============================================================================
module jtframe_sh #(
    parameter int width  = 5,
    parameter int stages = 24
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clk_en,
    input  logic                      clr,
    input  logic [width-1:0]          din,
    output logic [width-1:0]          drop,
    output logic [width*stages-1:0]   taps,
    output logic                      primed
);

    localparam int              c_TW   = width * stages;
    localparam int              c_CW   = $clog2(stages + 1);
    localparam logic [c_CW-1:0] c_FULL = c_CW'(stages);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    generate
        if (width < 1 || stages < 1) begin : g_bad_param
            $error("jtframe_sh: width and stages must both be at least 1");
        end
    endgenerate

    logic [c_TW-1:0] sr_q, sr_d;
    logic [c_CW-1:0] cnt_q, cnt_d;

    // clr has priority over clk_en so a flush never lets the new word in
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (clr) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (clk_en) begin
            sr_d = (sr_q << width) | c_TW'(din);
            if (cnt_q != c_FULL) begin
                cnt_d = cnt_q + c_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign taps   = sr_q;
    assign drop   = sr_q[c_TW-1 -: width];
    assign primed = (cnt_q == c_FULL);

endmodule
`default_nettype wire

// File: tb/tb_jtframe_sh.sv
`default_nettype none
// ============================================================================
// Module  : tb_jtframe_sh
// Brief   : self-checking bench for jtframe_sh (2x3 and 8x1 instances) against
//           a queue-based history model.
// Revision: 1.0
// ============================================================================
module tb_jtframe_sh;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       clk_en = 1'b0;
    logic       clr    = 1'b0;
    logic [7:0] din    = 8'h00;

    logic [1:0] drop_a;
    logic [5:0] taps_a;
    logic       primed_a;
    logic [7:0] drop_b;
    logic [7:0] taps_b;
    logic       primed_b;

    int n_checks = 0;
    int n_errors = 0;

    // history of words captured since last reset/clr, newest at the back
    logic [1:0] qa[$];
    logic [7:0] qb[$];

    always #5 clk = ~clk;

    jtframe_sh #(.width(2), .stages(3)) dut_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .clk_en (clk_en),
        .clr    (clr),
        .din    (din[1:0]),
        .drop   (drop_a),
        .taps   (taps_a),
        .primed (primed_a)
    );

    jtframe_sh #(.width(8), .stages(1)) dut_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .clk_en (clk_en),
        .clr    (clr),
        .din    (din),
        .drop   (drop_b),
        .taps   (taps_b),
        .primed (primed_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [5:0] model_taps_a();
        logic [5:0] t;
        t = '0;
        for (int k = 0; k < 3; k++)
            if (k < qa.size()) t[k*2 +: 2] = qa[qa.size()-1-k];
        return t;
    endfunction

    function automatic logic [7:0] model_taps_b();
        return (qb.size() > 0) ? qb[qb.size()-1] : 8'h00;
    endfunction

    task automatic model_clear();
        qa.delete();
        qb.delete();
    endtask

    task automatic model_edge();
        if (!rst_n || clr) begin
            model_clear();
        end else if (clk_en) begin
            qa.push_back(din[1:0]);
            if (qa.size() > 3) void'(qa.pop_front());
            qb.push_back(din);
            if (qb.size() > 1) void'(qb.pop_front());
        end
    endtask

    task automatic compare_all(input string tag);
        logic [5:0] ta;
        ta = model_taps_a();
        check({tag, "/drop_a"},   drop_a,   ta[5:4]);
        check({tag, "/taps_a"},   taps_a,   ta);
        check({tag, "/primed_a"}, primed_a, qa.size() == 3);
        check({tag, "/drop_b"},   drop_b,   model_taps_b());
        check({tag, "/taps_b"},   taps_b,   model_taps_b());
        check({tag, "/primed_b"}, primed_b, qb.size() == 1);
    endtask

    task automatic tick(input string tag, input logic en, input logic c, input logic [7:0] d);
        clk_en = en;
        clr    = c;
        din    = d;
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    // asynchronous reset pulse between edges, outputs checked before next edge
    task automatic async_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        model_clear();
        #1;
        compare_all(tag);
        rst_n = 1'b1;
    endtask

    initial begin
        #12;
        compare_all("reset");
        check("reset/drop_a", drop_a, 2'b00);
        check("reset/primed_a", primed_a, 1'b0);

        // single 2'b11 word travels through three stages
        rst_n = 1'b1;
        tick("p1", 1'b1, 1'b0, 8'h03);
        check("p1/stage0_release", taps_a[1:0], 2'b11);
        check("p1/drop_b", drop_b, 8'h03);
        tick("p2", 1'b1, 1'b0, 8'h00);
        tick("p3", 1'b1, 1'b0, 8'h00);
        check("p3/drop_a", drop_a, 2'b11);
        check("p3/primed_a", primed_a, 1'b1);
        tick("p4", 1'b1, 1'b0, 8'h00);
        check("p4/drop_a", drop_a, 2'b00);

        // sparse enables: delay counted in pulses, not clocks
        async_reset("cnt/rst");
        for (int p = 0; p < 4; p++) begin
            tick("cnt/pulse", 1'b1, 1'b0, 8'(p));
            for (int g = 0; g < 3; g++) tick("cnt/gap", 1'b0, 1'b0, 8'(p));
        end
        check("cnt/drop_a", drop_a, 2'd1);
        check("cnt/taps_a", taps_a, {2'd1, 2'd2, 2'd3});

        // full pipeline of 2'b10, then asynchronous reset
        for (int i = 0; i < 3; i++) tick("fill", 1'b1, 1'b0, 8'h02);
        check("fill/taps_a", taps_a, 6'b101010);
        async_reset("arst");
        check("arst/taps_a", taps_a, 6'h00);
        check("arst/primed_a", primed_a, 1'b0);

        // clr wins over a simultaneous enable
        for (int i = 0; i < 3; i++) tick("fill2", 1'b1, 1'b0, 8'h02);
        tick("clr", 1'b1, 1'b1, 8'h01);
        check("clr/taps_a", taps_a, 6'h00);
        check("clr/primed_a", primed_a, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick("postclr", 1'b1, 1'b0, 8'h00);
            check("postclr/no01", drop_a, 2'b00);
        end

        // single-stage instance
        tick("s1", 1'b1, 1'b0, 8'hA5);
        check("s1/drop_b", drop_b, 8'hA5);
        check("s1/taps_b", taps_b, 8'hA5);
        check("s1/primed_b", primed_b, 1'b1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 63) == 0) async_reset("rnd/arst");
            tick("rnd", 1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0),
                 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
